// File: rtl/ha_token_fork_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ha_token_fork_fifo
// Description : DEPTH-entry token FIFO that broadcasts each head token to
//               N_OUT consumers over independent valid/ready handshakes.
//               The head retires only after every consumer has accepted it.
//               Optional retired-token counter behind HA_TOKEN_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ha_token_fork_fifo #(
    parameter int DATA_BW = 32,
    parameter int DEPTH   = 4,
    parameter int N_OUT   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_BW-1:0]         in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [N_OUT*DATA_BW-1:0]   out_data,
    output logic [N_OUT-1:0]           out_valid,
    input  logic [N_OUT-1:0]           out_ready,
    output logic [$clog2(DEPTH):0]     occupancy
`ifdef HA_TOKEN_STATS_EN
    ,
    output logic [31:0]                tok_count
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [DATA_BW-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [N_OUT-1:0]   r_taken;

    logic               w_nonempty;
    logic               w_push;
    logic               w_pop;
    logic [N_OUT-1:0]   w_accept;
    logic [DATA_BW-1:0] w_head;

    // Handshake decode: ready depends only on the count register and reset.
    always_comb begin
        w_nonempty = (r_count != '0);
        in_ready   = (r_count != c_FULL) & rst;
        w_push     = in_valid & in_ready;
        out_valid  = {N_OUT{w_nonempty}} & ~r_taken;
        w_accept   = out_valid & out_ready;
        w_pop      = w_nonempty & (&(r_taken | w_accept));
        w_head     = w_nonempty ? r_mem[r_rd_ptr] : '0;
        occupancy  = r_count;
    end

    // Replicate the head token onto every consumer channel.
    generate
        for (genvar g = 0; g < N_OUT; g++) begin : g_out
            assign out_data[g*DATA_BW +: DATA_BW] = w_head;
        end
    endgenerate

    // Storage array; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy count and per-channel acceptance mask.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_taken  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                r_taken  <= '0;
            end else begin
                r_taken  <= r_taken | w_accept;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef HA_TOKEN_STATS_EN
    logic [31:0] r_tok_count;

    // Retired-token counter, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tok_count <= '0;
        end else if (w_pop) begin
            r_tok_count <= r_tok_count + 32'd1;
        end
    end

    assign tok_count = r_tok_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ha_token_fork_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ha_token_fork_fifo
// Description : Scoreboard bench for ha_token_fork_fifo (DEPTH=4, N_OUT=2).
//               Accepted pushes are queued per channel; a monitor compares
//               every consumer accept against its queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ha_token_fork_fifo;

    localparam int DATA_BW = 32;
    localparam int DEPTH   = 4;
    localparam int N_OUT   = 2;

    logic                     clk;
    logic                     rst;
    logic [DATA_BW-1:0]       in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic [N_OUT*DATA_BW-1:0] out_data;
    logic [N_OUT-1:0]         out_valid;
    logic [N_OUT-1:0]         out_ready;
    logic [$clog2(DEPTH):0]   occupancy;
`ifdef HA_TOKEN_STATS_EN
    logic [31:0]              tok_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [DATA_BW-1:0] q0[$];
    logic [DATA_BW-1:0] q1[$];

    ha_token_fork_fifo #(
        .DATA_BW (DATA_BW),
        .DEPTH   (DEPTH),
        .N_OUT   (N_OUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
`ifdef HA_TOKEN_STATS_EN
        ,
        .tok_count (tok_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare consumer accepts, then record accepted pushes.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid[0] && out_ready[0]) begin
                if (q0.size() == 0) begin
                    n_total++;
                    $display("FAIL ch0_accept: got unexpected token %0h expected none", out_data[0 +: DATA_BW]);
                end else begin
                    chk("ch0_data", 64'(out_data[0 +: DATA_BW]), 64'(q0.pop_front()));
                end
            end
            if (out_valid[1] && out_ready[1]) begin
                if (q1.size() == 0) begin
                    n_total++;
                    $display("FAIL ch1_accept: got unexpected token %0h expected none", out_data[DATA_BW +: DATA_BW]);
                end else begin
                    chk("ch1_data", 64'(out_data[DATA_BW +: DATA_BW]), 64'(q1.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                q0.push_back(in_data);
                q1.push_back(in_data);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hAA;
        out_ready = 2'b00;

        // Reset/idle: pushes ignored while reset is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("idle_occupancy", 64'(occupancy), 64'd0);
        chk("idle_in_ready",  64'(in_ready),  64'd1);

        // Broadcast one token with both consumers ready.
        in_valid  = 1'b1;
        in_data   = 32'h11111111;
        out_ready = 2'b11;
        tick();
        in_valid = 1'b0;
        chk("bc_out_valid", 64'(out_valid), 64'd3);
        chk("bc_occupancy", 64'(occupancy), 64'd1);
        tick();
        chk("bc_occ_after", 64'(occupancy), 64'd0);
        chk("bc_valid_after", 64'(out_valid), 64'd0);
        chk("bc_data_empty", 64'(out_data), 64'd0);
`ifdef HA_TOKEN_STATS_EN
        chk("bc_tok_count", 64'(tok_count), 64'd1);
`endif

        // Skewed consumers: channel 0 runs ahead of channel 1.
        out_ready = 2'b01;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        in_valid = 1'b0;
        chk("skew_out_valid", 64'(out_valid), 64'd2);
        chk("skew_occupancy", 64'(occupancy), 64'd2);
        chk("skew_ch1_head",  64'(out_data[DATA_BW +: DATA_BW]), 64'hA);
        out_ready = 2'b10;
        tick();
        chk("skew_next_valid", 64'(out_valid), 64'd3);
        chk("skew_next_data",  64'(out_data), {32'hB, 32'hB});
        chk("skew_next_occ",   64'(occupancy), 64'd1);
        out_ready = 2'b11;
        tick();
        chk("skew_drained", 64'(occupancy), 64'd0);

        // Full: five push attempts against stalled consumers.
        out_ready = 2'b00;
        for (int v = 1; v <= 5; v++) begin
            in_valid = 1'b1;
            in_data  = 32'(v);
            tick();
        end
        chk("full_occupancy", 64'(occupancy), 64'd4);
        chk("full_in_ready",  64'(in_ready),  64'd0);
        out_ready = 2'b11;
        tick();
        chk("full_ready_after_pop", 64'(in_ready),  64'd1);
        chk("full_occ_after_pop",   64'(occupancy), 64'd3);
        tick();
        in_valid = 1'b0;
        chk("full_occ_push_pop", 64'(occupancy), 64'd3);
        repeat (3) tick();
        chk("full_drained", 64'(occupancy), 64'd0);

        // Streaming 20 tokens back to back across pointer wraps.
        out_ready = 2'b11;
        for (int v = 0; v < 20; v++) begin
            in_valid = 1'b1;
            in_data  = 32'(v);
            tick();
            chk("stream_occupancy", 64'(occupancy), 64'd1);
            chk("stream_out_valid", 64'(out_valid), 64'd3);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", 64'(occupancy), 64'd0);
`ifdef HA_TOKEN_STATS_EN
        chk("stream_tok_count", 64'(tok_count), 64'd28);
`endif

        // Mid-operation reset with a partially accepted head.
        out_ready = 2'b01;
        for (int v = 1; v <= 3; v++) begin
            in_valid = 1'b1;
            in_data  = 32'(v);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 2'b00;
        chk("mid_occupancy", 64'(occupancy), 64'd3);
        chk("mid_out_valid", 64'(out_valid), 64'd2);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        tick();
        chk("mid_rst_occ",      64'(occupancy), 64'd0);
        chk("mid_rst_valid",    64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready),  64'd0);
        rst = 1'b1;
        #1;
        chk("mid_rel_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = 32'h7;
        tick();
        in_valid = 1'b0;
        chk("mid_push_valid", 64'(out_valid), 64'd3);
        chk("mid_push_data",  64'(out_data), {32'h7, 32'h7});
        out_ready = 2'b11;
        tick();
        chk("mid_drained", 64'(occupancy), 64'd0);
`ifdef HA_TOKEN_STATS_EN
        chk("mid_tok_count", 64'(tok_count), 64'd1);
`endif

        @(negedge clk);
        chk("ch0_queue_empty", 64'(q0.size()), 64'd0);
        chk("ch1_queue_empty", 64'(q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ha_token_fork_fifo.md
# ha_token_fork_fifo

Parametrised token channel for generated dataflow graphs. It buffers tokens from one producer in a DEPTH-entry FIFO and broadcasts each token to N_OUT consumers over independent valid/ready handshakes. A token retires only after every consumer has accepted it. It replaces the fixed 32-bit, zero-storage, two-way token wire plus fan-out used between input and output wrappers, so slow consumers no longer stall fast ones token-by-token.

## Interface
Parameters:
- DATA_BW, 32, token width in bits (≥1)
- DEPTH, 4, FIFO entries; power of two, ≥2
- N_OUT, 2, consumer channel count (1..16)

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  reset; synchronous, active-low
- in_data  input  DATA_BW  producer token
- in_valid  input  1  producer token valid
- in_ready  output  1  FIFO can accept a token
- out_data  output  N_OUT*DATA_BW  head token replicated; channel i at bits [i*DATA_BW +: DATA_BW]
- out_valid  output  N_OUT  per-channel head valid
- out_ready  input  N_OUT  per-channel consumer ready
- occupancy  output  $clog2(DEPTH)+1  stored token count, 0..DEPTH
- tok_count  output  32  retired-token counter; present only with HA_TOKEN_STATS_EN

## Operation
- Storage: DEPTH×DATA_BW array, wr_ptr/rd_ptr of $clog2(DEPTH) bits wrap modulo DEPTH, count register 0..DEPTH.
- Push: in_valid & in_ready writes mem[wr_ptr], wr_ptr+1.
- in_ready = (count != DEPTH) & rst. It is combinational from the count register only, with no dependency on out_ready.
- Per-channel taken[N_OUT] mask records consumers that have accepted the current head.
- out_valid[i] = (count != 0) & ~taken[i].
- out_data = mem[rd_ptr] on every channel when count != 0. It is all zeros when count == 0.
- Accept on channel i: out_valid[i] & out_ready[i].
- Pop condition: count != 0 and for all i (taken[i] | accept[i]).
  - On pop: rd_ptr+1 and taken cleared to 0.
  - Otherwise: taken |= accept.
- Simultaneous push and pop: count unchanged, both pointers advance. With count==DEPTH, push is impossible because in_ready=0. A pop in that cycle makes in_ready 1 the next cycle.
- Empty and push in the same cycle: no bypass. The token is visible the next cycle.
- occupancy = count.
- Reset (rst=0 at a clk edge):
  - count, wr_ptr, rd_ptr and taken go to 0. tok_count goes to 0.
  - The array is not cleared.
  - Outputs after that edge: out_valid=0, out_data=0, occupancy=0.
  - While rst=0, in_ready=0 (combinational) and pushes are ignored.
- Reset mid-operation drops all stored tokens and partial-acceptance state. The first edge with rst=1 behaves as an empty FIFO.

## Timing
- Latency: a token pushed at edge k is on out_valid/out_data after edge k (one cycle), provided all older tokens have retired.
- Throughput: one token per cycle in and out when all out_ready=1 and count>0.
- A consumer may accept the head in an earlier cycle than the others. That channel's out_valid drops the cycle after its accept and stays low until the pop.
- out_valid[i] never falls without an accept on i, except under reset. out_data is stable while any out_valid bit is high.
- in_valid may be held or withdrawn freely. The producer must keep in_data stable only in the accepting cycle.

## Configuration
- HA_TOKEN_STATS_EN defined:
  - tok_count port exists and increments by 1 on each pop.
  - It wraps from 0xFFFFFFFF to 0 and resets to 0.
- Undefined: no tok_count port and no counter logic. All other behaviour is identical.

## Test plan
- Reset/idle: hold rst=0 for 3 cycles with in_valid=1, in_data=0xAA -> out_valid=2'b00, in_ready=0, occupancy=0. After release, occupancy stays 0 until the first accepted push.
- Broadcast: DEPTH=4, N_OUT=2, push 0x11111111 with out_ready=2'b11 -> next cycle out_valid=2'b11 on both channels; popped that cycle; occupancy back to 0; tok_count=1.
- Skewed consumers: push 0xA, 0xB with out_ready=2'b01 -> channel 0 takes 0xA and then its out_valid[0] goes low. Then set out_ready=2'b10 -> channel 1 takes 0xA, pop occurs, both channels see 0xB next cycle.
- Full: out_ready=0, push 5 tokens 1..5 -> tokens 1..4 stored, in_ready=0 after the 4th, occupancy=4. Pop token 1 with out_ready=2'b11 -> in_ready=1 the next cycle; token 5 accepted.
- Wrap and streaming: 20 back-to-back tokens 0..19 with out_ready=2'b11 -> outputs in order 0..19, one per cycle, pointers wrap 5 times, tok_count=20.
- Mid-operation reset: with occupancy=3 and taken=2'b01, assert rst=0 for one cycle -> occupancy=0, out_valid=0. The next push 0x7 appears on both channels with taken cleared.
